// File: rtl/fft_cbfp_sched.sv
`default_nettype none
// ============================================================================
//  Module      : fft_cbfp_sched
//  Description : Frame scheduler for the CBFP FFT datapath. Accepts complete
//                frames from the upstream buffer, streams them beat by beat
//                into the datapath, collects one block exponent per CBFP
//                block into the exponent table, and enforces an inter-frame
//                gap so the datapath beat counter restarts cleanly.
//  Revision    : 1.0 - initial release
// ============================================================================
module fft_cbfp_sched #(
    parameter int BEATS_PER_FRAME = 32,
    parameter int BEATS_PER_BLOCK = 4,
    parameter int GAP_CYCLES      = 2,
    parameter int TIMEOUT         = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       s_frame_req,
    output logic       s_frame_ack,
    output logic       s_rd_en,
    output logic [4:0] s_rd_addr,
    output logic       dp_valid,
    input  logic       dp_dout_valid,
    input  logic [4:0] dp_blk_exp,
    input  logic       abort,
    output logic       exp_wr_en,
    output logic [2:0] exp_wr_addr,
    output logic [4:0] exp_wr_data,
    output logic       frame_done,
    output logic       busy,
    output logic [5:0] out_beat_cnt,
    output logic       err_overrun,
    output logic       err_timeout
);

    localparam int              TMR_W         = $clog2(TIMEOUT + 1);
    localparam int              GAP_W         = $clog2(GAP_CYCLES + 1);
    localparam logic [5:0]      C_FRAME_BEATS = 6'(BEATS_PER_FRAME);
    localparam logic [4:0]      C_LAST_ADDR   = 5'(BEATS_PER_FRAME - 1);
    localparam logic [5:0]      C_BLK_BEATS   = 6'(BEATS_PER_BLOCK);
    localparam logic [TMR_W-1:0] C_TMR_LAST   = TMR_W'(TIMEOUT - 1);
    localparam logic [GAP_W-1:0] C_GAP_LAST   = GAP_W'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_DRAIN = 3'd2,
        S_DONE  = 3'd3,
        S_GAP   = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [TMR_W-1:0]   r_tmr;
    logic [GAP_W-1:0]   r_gap;

    logic               r_frame_ack;
    logic               r_rd_en;
    logic [4:0]         r_rd_addr;
    logic               r_dp_valid;
    logic               r_exp_wr_en;
    logic [2:0]         r_exp_wr_addr;
    logic [4:0]         r_exp_wr_data;
    logic               r_frame_done;
    logic               r_busy;
    logic [5:0]         r_cnt;
    logic               r_err_overrun;
    logic               r_err_timeout;

    logic               w_count_st;
    logic               w_beat_ok;
    logic               w_blk_first;
    logic               w_overrun;
    logic               w_timeout;

    // Beats are only legitimate while a frame is in flight and not yet complete
    assign w_count_st  = (r_state == S_READ) || (r_state == S_DRAIN) || (r_state == S_DONE);
    assign w_beat_ok   = dp_dout_valid && w_count_st && (r_cnt < C_FRAME_BEATS);
    assign w_blk_first = ((r_cnt % C_BLK_BEATS) == 6'd0);
    assign w_overrun   = dp_dout_valid && (!w_count_st || (r_cnt >= C_FRAME_BEATS));
    assign w_timeout   = (r_state == S_DRAIN) && (r_cnt != C_FRAME_BEATS) && (r_tmr == C_TMR_LAST);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode; abort overrides everything including a new request
    always_comb begin
        w_next = r_state;
        if (abort) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (s_frame_req) w_next = S_READ;
                S_READ:  if (r_rd_addr == C_LAST_ADDR) w_next = S_DRAIN;
                S_DRAIN: if ((r_cnt == C_FRAME_BEATS) || w_timeout) w_next = S_DONE;
                S_DONE:  w_next = S_GAP;
                S_GAP:   if (r_gap == C_GAP_LAST) w_next = S_IDLE;
                default: w_next = S_IDLE;
            endcase
        end
    end

    // Registered outputs, beat counting, exponent capture and sticky errors
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_frame_ack   <= 1'b0;
            r_rd_en       <= 1'b0;
            r_rd_addr     <= 5'd0;
            r_dp_valid    <= 1'b0;
            r_exp_wr_en   <= 1'b0;
            r_exp_wr_addr <= 3'd0;
            r_exp_wr_data <= 5'd0;
            r_frame_done  <= 1'b0;
            r_busy        <= 1'b0;
            r_cnt         <= 6'd0;
            r_err_overrun <= 1'b0;
            r_err_timeout <= 1'b0;
            r_tmr         <= '0;
            r_gap         <= '0;
        end else begin
            r_frame_ack  <= (r_state == S_IDLE) && (w_next == S_READ);
            r_rd_en      <= (w_next == S_READ);
            r_rd_addr    <= ((r_state == S_READ) && (w_next == S_READ)) ? r_rd_addr + 5'd1 : 5'd0;
            // Buffer read has one cycle of latency, so the datapath strobe trails the read strobe
            r_dp_valid   <= r_rd_en && !abort;
            r_frame_done <= (w_next == S_DONE);
            r_busy       <= (w_next != S_IDLE);

            if (w_next == S_IDLE) begin
                r_cnt <= 6'd0;
            end else if (w_beat_ok) begin
                r_cnt <= r_cnt + 6'd1;
            end

            r_exp_wr_en <= w_beat_ok && w_blk_first && !abort;
            if (w_beat_ok && w_blk_first && !abort) begin
                r_exp_wr_addr <= 3'(r_cnt / C_BLK_BEATS);
                r_exp_wr_data <= dp_blk_exp;
            end

            if (w_overrun) begin
                r_err_overrun <= 1'b1;
            end
            if (w_timeout && !abort) begin
                r_err_timeout <= 1'b1;
            end

            r_tmr <= ((r_state == S_DRAIN) && (w_next == S_DRAIN)) ? r_tmr + TMR_W'(1) : '0;
            r_gap <= ((r_state == S_GAP) && (w_next == S_GAP)) ? r_gap + GAP_W'(1) : '0;
        end
    end

    assign s_frame_ack  = r_frame_ack;
    assign s_rd_en      = r_rd_en;
    assign s_rd_addr    = r_rd_addr;
    assign dp_valid     = r_dp_valid;
    assign exp_wr_en    = r_exp_wr_en;
    assign exp_wr_addr  = r_exp_wr_addr;
    assign exp_wr_data  = r_exp_wr_data;
    assign frame_done   = r_frame_done;
    assign busy         = r_busy;
    assign out_beat_cnt = r_cnt;
    assign err_overrun  = r_err_overrun;
    assign err_timeout  = r_err_timeout;

endmodule
`default_nettype wire

// File: doc/fft_cbfp_sched.md
FFT_CBFP_SCHED -- requirements
Module: fft_cbfp_sched

Interface
REQ-001 Parameter BEATS_PER_FRAME, default 32, is the number of 16-lane beats per 512-point frame.
REQ-002 Parameter BEATS_PER_BLOCK, default 4, is the number of beats per CBFP block (64 samples).
REQ-003 Parameter GAP_CYCLES, default 2, is the minimum number of dp_valid-low cycles between frames; legal range is 1 or more.
REQ-004 Parameter TIMEOUT, default 64, is the maximum number of DRAIN cycles before the block declares a timeout.
REQ-005 The block has one clock; reset is synchronous and active-low.
REQ-006 clk  input  1  system clock; all logic is on the rising edge.
REQ-007 rst_n  input  1  synchronous active-low reset.
REQ-008 s_frame_req  input  1  upstream frame buffer holds a complete frame.
REQ-009 s_frame_ack  output  1  single-cycle pulse: frame accepted.
REQ-010 s_rd_en  output  1  read strobe to the frame buffer, one beat per cycle.
REQ-011 s_rd_addr  output  5  beat index being read.
REQ-012 dp_valid  output  1  drives the CBFP datapath i_valid.
REQ-013 dp_dout_valid  input  1  CBFP datapath output-beat valid.
REQ-014 dp_blk_exp  input  5  CBFP common shift exponent, valid with dp_dout_valid.
REQ-015 abort  input  1  synchronous frame abort.
REQ-016 exp_wr_en  output  1  exponent-table write strobe.
REQ-017 exp_wr_addr  output  3  exponent-table block index.
REQ-018 exp_wr_data  output  5  block exponent.
REQ-019 frame_done  output  1  single-cycle pulse: frame fully drained.
REQ-020 busy  output  1  high whenever the state is not IDLE.
REQ-021 out_beat_cnt  output  6  output beats counted in the current frame.
REQ-022 err_overrun  output  1  sticky: an unexpected or excess output beat occurred.
REQ-023 err_timeout  output  1  sticky: the DRAIN state timed out.

Function
REQ-024 The FSM states are IDLE, READ, DRAIN, DONE and GAP; all outputs are registered.
REQ-025 IDLE with s_frame_req=1 at edge N: the FSM enters READ, and in cycle N+1 s_frame_ack=1, s_rd_en=1 and s_rd_addr=0.
REQ-026 READ: s_rd_en stays high for BEATS_PER_FRAME consecutive cycles with s_rd_addr incrementing 0..31, with no bubbles; after address 31 the FSM enters DRAIN.
REQ-027 dp_valid equals s_rd_en delayed by one cycle, to match the 1-cycle buffer read latency; dp_valid is therefore contiguous for 32 cycles.
REQ-028 out_beat_cnt increments on each dp_dout_valid while in READ, DRAIN or DONE, up to 32.
REQ-029 On a dp_dout_valid beat with pre-increment count k, where k%4==0 and k<32, the next cycle carries exp_wr_en=1, exp_wr_addr=k/4 and exp_wr_data=dp_blk_exp.
REQ-030 DRAIN: when out_beat_cnt reaches 32, the FSM enters DONE.
REQ-031 DRAIN timeout: if TIMEOUT cycles elapse first, err_timeout is set and the FSM enters DONE.
REQ-032 DONE lasts one cycle with frame_done=1, then the FSM enters GAP.
REQ-033 GAP holds for GAP_CYCLES, then the FSM enters IDLE; out_beat_cnt clears on entry to IDLE.
REQ-034 Back-to-back frames: dp_valid is low for at least GAP_CYCLES between frames, so the datapath beat counter always restarts at 0.
REQ-035 s_frame_req is ignored in every state except IDLE; a held request is accepted on the first IDLE cycle.
REQ-036 Overrun: dp_dout_valid in IDLE or GAP, or with out_beat_cnt=32, sets err_overrun; no exp write occurs and the count saturates at 32.
REQ-037 abort=1 in any state: on the next cycle the FSM is in IDLE, s_rd_en=0, dp_valid=0, and the counters are cleared.
REQ-038 An abort produces no frame_done and no exp write for beats arriving in the same cycle.
REQ-039 abort takes priority over s_frame_req in the same cycle.
REQ-040 err_overrun and err_timeout clear only on reset.

Reset
REQ-041 While rst_n=0 at a clock edge, the FSM enters IDLE.
REQ-042 During reset, every output resets to 0: s_frame_ack, s_rd_en, s_rd_addr, dp_valid, exp_wr_en, exp_wr_addr, exp_wr_data, frame_done, busy, out_beat_cnt, err_overrun and err_timeout.
REQ-043 Reset asserted mid-frame discards the frame, as abort does.
REQ-044 The first request after reset is accepted normally.

Verification
REQ-045 Single frame: s_frame_req at edge 10; datapath model returns 32 beats starting 6 cycles after the first dp_valid with exponents 3,3,3,3,5,5,5,5,... -> s_frame_ack at cycle 11, dp_valid in cycles 12..43, eight exp writes at addresses 0..7 with data from beats 0,4,...,28, frame_done once, busy low after GAP.
REQ-046 Back-to-back: s_frame_req held high for 3 frames -> three acks, dp_valid low for at least 2 cycles between bursts, 24 exp writes, 3 frame_done pulses.
REQ-047 Timeout: datapath returns only 20 beats -> err_timeout=1 sixty-four DRAIN cycles later, frame_done still pulses, and the next frame proceeds.
REQ-048 Overrun: inject dp_dout_valid while in IDLE, and separately a 33rd beat -> err_overrun=1, no exp write, out_beat_cnt stays at 32.
REQ-049 Abort at s_rd_addr=17 -> next cycle s_rd_en=0, dp_valid=0, busy=0, no frame_done; a new request 1 cycle later gets an ack.
REQ-050 rst_n=0 for 1 cycle mid-DRAIN -> all outputs 0 on the next cycle, and both error flags clear.
